// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared types and constants for the PWM fade controller.
//   fade_state_t : controller state encoding (IDLE / WAIT / STEP)
//   DEF_*        : default widths matching the downstream PWM counter
//   sat_clamp    : min(value, limit), used to keep the fade target inside the period
package pwm_fade_pkg;

  localparam int unsigned DEF_WIDTH  = 28;
  localparam int unsigned DEF_STEP_W = 16;
  localparam int unsigned DEF_DIV_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STEP
  } fade_state_t;

  // Wide operands let every caller zero-extend its own width without truncation.
  function automatic logic [63:0] sat_clamp(input logic [63:0] value,
                                            input logic [63:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/pwm_wrap_prescaler.sv
// pwm_wrap_prescaler: counts PWM period wraps and flags every dv-th one.
//   CLK, RST    : clock, synchronous active-high reset
//   clr         : clears the wrap count (takes priority over counting)
//   en          : counting enable
//   period_wrap : one-cycle pulse from the PWM counter clear
//   dv          : wraps per tick, must be >= 1
//   tick        : high in the same cycle as the wrap that completes the dv-th period
module pwm_wrap_prescaler
  import pwm_fade_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic             period_wrap,
  input  logic [DIV_W-1:0] dv,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic [DIV_W:0]   count_inc;

  assign count_inc = {1'b0, count} + (DIV_W + 1)'(1);

  // Combinational so the controller can enter STEP on the very edge that
  // samples the completing wrap.
  assign tick = en && period_wrap && (count_inc == {1'b0, dv});

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      count <= '0;
    end else if (en && period_wrap) begin
      count <= tick ? '0 : count_inc[DIV_W-1:0];
    end
  end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: ramps the PWM counter's Decode toward a software target in
// equal steps, updating Period/Decode only around period boundaries.
//   CLK, RST    : clock, synchronous active-high reset
//   period_in   : requested PWM period (sampled on start)
//   target_in   : requested final decode (sampled on start, clamped to period)
//   step_in     : decode increment per step (sampled on start, 0 treated as 1)
//   div_in      : PWM periods per step (sampled on start, 0 treated as 1)
//   start       : one-cycle command pulse
//   abort       : one-cycle stop pulse, wins over start
//   period_wrap : one-cycle pulse on the last cycle of each PWM period
//   period_out  : Period to the PWM counter
//   decode_out  : Decode to the PWM counter
//   busy        : fade in progress
//   done        : one-cycle pulse when decode_out lands on the target
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STEP_W = DEF_STEP_W,
  parameter int unsigned DIV_W  = DEF_DIV_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  period_in,
  input  logic [WIDTH-1:0]  target_in,
  input  logic [STEP_W-1:0] step_in,
  input  logic [DIV_W-1:0]  div_in,
  input  logic              start,
  input  logic              abort,
  input  logic              period_wrap,
  output logic [WIDTH-1:0]  period_out,
  output logic [WIDTH-1:0]  decode_out,
  output logic              busy,
  output logic              done
);

  fade_state_t       state, state_next;
  logic [WIDTH-1:0]  tgt, per;
  logic [STEP_W-1:0] stp;
  logic [DIV_W-1:0]  dv;
  logic              per_pending;
  logic              go;
  logic              tick;
  logic [WIDTH:0]    diff, stp_ext;
  logic              reach;
  logic [WIDTH-1:0]  decode_next;
  logic              done_next;

  assign go = start && !abort;

  pwm_wrap_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .CLK        (CLK),
    .RST        (RST),
    .clr        (start || abort),
    .en         ((state == WAIT) && !start && !abort),
    .period_wrap(period_wrap),
    .dv         (dv),
    .tick       (tick)
  );

  // Distance to target at WIDTH+1 bits so the step test can never wrap.
  always_comb begin
    if (tgt >= decode_out) diff = {1'b0, tgt} - {1'b0, decode_out};
    else                   diff = {1'b0, decode_out} - {1'b0, tgt};
    stp_ext = (WIDTH + 1)'(stp);
    reach   = (diff <= stp_ext);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else if (start) begin
      state_next = WAIT;
    end else begin
      case (state)
        WAIT:    if (tick) state_next = STEP;
        STEP:    state_next = reach ? IDLE : WAIT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    decode_next = decode_out;
    done_next   = 1'b0;
    if ((state == STEP) && !start && !abort) begin
      if (reach) begin
        decode_next = tgt;
        done_next   = 1'b1;
      end else if (tgt > decode_out) begin
        decode_next = decode_out + WIDTH'(stp);
      end else begin
        decode_next = decode_out - WIDTH'(stp);
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      period_out  <= '0;
      decode_out  <= '0;
      done        <= 1'b0;
      tgt         <= '0;
      per         <= '0;
      stp         <= '0;
      dv          <= '0;
      per_pending <= 1'b0;
    end else begin
      decode_out <= decode_next;
      done       <= done_next;
      if (go) begin
        tgt <= WIDTH'(sat_clamp(64'(target_in), 64'(period_in)));
        stp <= (step_in == '0) ? STEP_W'(1) : step_in;
        dv  <= (div_in == '0) ? DIV_W'(1) : div_in;
        per <= period_in;
        // A zero period never produces a wrap, so apply the new one at once.
        if (period_out == '0) begin
          period_out  <= period_in;
          per_pending <= 1'b0;
        end else begin
          per_pending <= 1'b1;
        end
      end else if (abort) begin
        per_pending <= 1'b0;
      end else if (per_pending && period_wrap && (state != IDLE)) begin
        period_out  <= per;
        per_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
module tb_pwm_fade_ctrl;

  localparam int WIDTH  = 28;
  localparam int STEP_W = 16;
  localparam int DIV_W  = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic [WIDTH-1:0]  period_in;
  logic [WIDTH-1:0]  target_in;
  logic [STEP_W-1:0] step_in;
  logic [DIV_W-1:0]  div_in;
  logic              start;
  logic              abort;
  logic              period_wrap;
  logic [WIDTH-1:0]  period_out;
  logic [WIDTH-1:0]  decode_out;
  logic              busy;
  logic              done;

  always #5 CLK = ~CLK;

  pwm_fade_ctrl #(
    .WIDTH (WIDTH),
    .STEP_W(STEP_W),
    .DIV_W (DIV_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .period_in  (period_in),
    .target_in  (target_in),
    .step_in    (step_in),
    .div_in     (div_in),
    .start      (start),
    .abort      (abort),
    .period_wrap(period_wrap),
    .period_out (period_out),
    .decode_out (decode_out),
    .busy       (busy),
    .done       (done)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state: what the PWM counter should currently be seeing.
  longint m_decode  = 0;
  longint m_period  = 0;
  longint m_pend    = 0;
  bit     m_pending = 1'b0;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // One whole fade scenario: the model derives the full list of decode values
  // from target/step arithmetic, then the bench walks the wraps and checks
  // each value lands exactly two cycles after the completing wrap.
  task automatic run_fade(input string name, input longint per, input longint tgt,
                          input longint stp, input longint dv, input int gap,
                          input bit with_wrap, input int max_steps);
    longint t, s, d, cur, dd;
    longint exp_q[$];
    t = (tgt > per) ? per : tgt;
    s = (stp == 0) ? 1 : stp;
    d = (dv == 0) ? 1 : dv;
    cur = m_decode;
    forever begin
      dd = (t > cur) ? t - cur : cur - t;
      if (dd <= s) begin
        exp_q.push_back(t);
        break;
      end
      cur = (t > cur) ? cur + s : cur - s;
      exp_q.push_back(cur);
    end

    period_in   = WIDTH'(per);
    target_in   = WIDTH'(tgt);
    step_in     = STEP_W'(stp);
    div_in      = DIV_W'(dv);
    start       = 1'b1;
    period_wrap = with_wrap;
    cyc();
    start       = 1'b0;
    period_wrap = 1'b0;
    if (m_period == 0) m_period = per;
    else begin
      m_pending = 1'b1;
      m_pend    = per;
    end
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s start_flags: busy=%0b done=%0b want busy=1 done=0", name, busy, done);
    end
    total++;
    if (period_out !== WIDTH'(m_period)) begin
      bad++;
      $display("FAIL %s start_period: got %0d want %0d", name, period_out, m_period);
    end
    repeat (gap) cyc();

    for (int i = 0; i < exp_q.size(); i++) begin
      for (int k = 1; k <= d; k++) begin
        automatic bit fin = (k == d) && (i == exp_q.size() - 1);
        period_wrap = 1'b1;
        cyc();
        period_wrap = 1'b0;
        if (m_pending) begin
          m_period  = m_pend;
          m_pending = 1'b0;
        end
        total++;
        if (period_out !== WIDTH'(m_period)) begin
          bad++;
          $display("FAIL %s period step%0d wrap%0d: got %0d want %0d", name, i, k, period_out, m_period);
        end
        total++;
        if (decode_out !== WIDTH'(m_decode) || done !== 1'b0) begin
          bad++;
          $display("FAIL %s early step%0d wrap%0d: decode=%0d done=%0b want decode=%0d done=0",
                   name, i, k, decode_out, done, m_decode);
        end
        cyc();
        if (k == d) m_decode = exp_q[i];
        total++;
        if (decode_out !== WIDTH'(m_decode) || done !== fin || busy !== !fin) begin
          bad++;
          $display("FAIL %s step%0d wrap%0d: decode=%0d done=%0b busy=%0b want decode=%0d done=%0b busy=%0b",
                   name, i, k, decode_out, done, busy, m_decode, fin, !fin);
        end
        for (int g = 0; g < gap; g++) begin
          cyc();
          total++;
          if (decode_out !== WIDTH'(m_decode) || done !== 1'b0) begin
            bad++;
            $display("FAIL %s hold step%0d gap%0d: decode=%0d done=%0b want decode=%0d done=0",
                     name, i, g, decode_out, done, m_decode);
          end
        end
      end
      if (max_steps > 0 && i + 1 == max_steps) return;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; abort = 1'b0; period_wrap = 1'b0;
    period_in = '0; target_in = '0; step_in = '0; div_in = '0;
    repeat (3) cyc();
    RST = 1'b0;
    cyc();
    m_decode = 0; m_period = 0; m_pending = 1'b0;
    total++;
    if (period_out !== '0 || decode_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: period=%0d decode=%0d busy=%0b done=%0b want all 0",
               period_out, decode_out, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      period_wrap = 1'b1; cyc(); period_wrap = 1'b0; cyc();
      total++;
      if (period_out !== '0 || decode_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle_wrap%0d: period=%0d decode=%0d busy=%0b done=%0b want all 0",
                 i, period_out, decode_out, busy, done);
      end
    end
  endtask

  task automatic test_fade_up();
    run_fade("fade_up", 100, 40, 10, 2, 98, 1'b0, 0);
  endtask

  task automatic test_fade_down();
    run_fade("fade_down", 100, 5, 10, 1, 6, 1'b0, 0);
  endtask

  task automatic test_clamp();
    run_fade("clamp", 50, 80, 0, 0, 3, 1'b0, 0);
  endtask

  task automatic test_abort();
    run_fade("abort_pre", 50, 0, 10, 1, 3, 1'b0, 3);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    m_pending = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || decode_out !== WIDTH'(m_decode)) begin
      bad++;
      $display("FAIL abort_now: busy=%0b done=%0b decode=%0d want busy=0 done=0 decode=%0d",
               busy, done, decode_out, m_decode);
    end
    for (int i = 0; i < 5; i++) begin
      period_wrap = 1'b1; cyc(); period_wrap = 1'b0; cyc(); cyc();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || decode_out !== 28'd20) begin
        bad++;
        $display("FAIL abort_hold%0d: busy=%0b done=%0b decode=%0d want busy=0 done=0 decode=20",
                 i, busy, done, decode_out);
      end
    end
    run_fade("abort_post", 50, 0, 10, 1, 3, 1'b0, 0);
  endtask

  task automatic test_simultaneous();
    period_in = 28'd50; target_in = 28'd30; step_in = 16'd5; div_in = 16'd1;
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_abort_busy: got %0b want 0", busy);
    end
    for (int i = 0; i < 3; i++) begin
      period_wrap = 1'b1; cyc(); period_wrap = 1'b0; cyc();
      total++;
      if (busy !== 1'b0 || decode_out !== WIDTH'(m_decode) || done !== 1'b0) begin
        bad++;
        $display("FAIL start_abort_idle%0d: busy=%0b decode=%0d done=%0b want busy=0 decode=%0d done=0",
                 i, busy, decode_out, done, m_decode);
      end
    end
    run_fade("start_wrap", 50, 20, 10, 2, 3, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    run_fade("retarget_a", 60, 50, 5, 1, 2, 1'b0, 2);
    run_fade("retarget_b", 60, 10, 7, 1, 2, 1'b0, 0);
    run_fade("same_target", 60, 10, 3, 2, 2, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    run_fade("pre_reset", 60, 40, 5, 1, 2, 1'b0, 2);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    m_decode = 0; m_period = 0; m_pending = 1'b0;
    total++;
    if (period_out !== '0 || decode_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: period=%0d decode=%0d busy=%0b done=%0b want all 0",
               period_out, decode_out, busy, done);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      longint per, tgt, stp, dv;
      int gap;
      bit ww;
      per = longint'($urandom_range(1, 150));
      tgt = longint'($urandom_range(0, 160));
      stp = longint'($urandom_range(0, 20));
      dv  = longint'($urandom_range(0, 2));
      gap = int'($urandom_range(2, 5));
      ww  = 1'($urandom_range(0, 1));
      run_fade($sformatf("rand%0d", n), per, tgt, stp, dv, gap, ww, 0);
    end
  endtask

  initial begin
    test_reset();
    test_fade_up();
    test_fade_down();
    test_clamp();
    test_abort();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
